// File: rtl/midi_note_decoder_pkg.sv
// Shared definitions for the MIDI note decoder: parser state encoding,
// MIDI status nibbles and a helper that maps a channel status byte onto
// the parser state that collects its data bytes.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NOTE_BYTE = 3'd1,
    VEL_BYTE  = 3'd2,
    SKIP1     = 3'd3,
    SKIP2     = 3'd4
  } parser_state_t;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PROG       = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;
  localparam logic [3:0] SYS        = 4'hF;
  localparam logic [7:0] RT_MIN     = 8'hF8;

  // State entered after a channel status byte (0x80..0xEF):
  // note on/off for our channel collects note+velocity, one-data-byte
  // messages skip one byte, everything else skips two.
  function automatic parser_state_t status_entry(input logic [7:0] status,
                                                 input logic [3:0] ch);
    parser_state_t s;
    if ((status[7:4] == NOTE_ON || status[7:4] == NOTE_OFF) && status[3:0] == ch)
      s = NOTE_BYTE;
    else if (status[7:4] == PROG || status[7:4] == CHAN_PRESS)
      s = SKIP1;
    else
      s = SKIP2;
    return s;
  endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// Byte-stream and note-output bundle for the MIDI note decoder.
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is
// no ready because a UART receiver cannot be stalled -- every byte
// presented with rx_valid high is consumed on that clock edge.
// parser_state is a read-only view of the parser FSM for observation.
interface midi_note_decoder_if;
  import synth_pkg::*;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    note_out;
  logic [6:0]    velocity;
  logic          key_on;
  logic          note_strobe;
  parser_state_t parser_state;

  modport master (
    output rx_data, rx_valid,
    input  note_out, velocity, key_on, note_strobe, parser_state
  );

  modport slave (
    input  rx_data, rx_valid,
    output note_out, velocity, key_on, note_strobe, parser_state
  );
endinterface

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note decoder, last-note priority. Parses a raw MIDI
// byte stream and drives a single voice's note number, velocity and gate.
// Optional macro MIDI_RUNNING_STATUS_EN: data bytes arriving in IDLE
// reuse the retained running status; otherwise they are dropped.
module midi_note_decoder
  import synth_pkg::*;
#(
  parameter logic [3:0] MIDI_CH = 4'd0
) (
  input logic           Clk,
  input logic           Reset,
  midi_note_decoder_if.slave bus
);

  parser_state_t state_q, state_d;
  logic [7:0]    run_status_q, run_status_d;  // 0 means no running status
  logic [6:0]    pending_q, pending_d;
  logic [6:0]    note_q, note_d;
  logic [6:0]    vel_q, vel_d;
  logic          key_on_q, key_on_d;
  logic          strobe_q, strobe_d;

  logic is_status;
  logic is_realtime;
  logic is_system;
  logic note_on_msg;

  assign is_status   = bus.rx_data[7];
  assign is_realtime = (bus.rx_data >= RT_MIN);
  assign is_system   = (bus.rx_data[7:4] == SYS);
  // Running status is latched on every channel status byte, so it always
  // identifies the message whose velocity byte is being received.
  assign note_on_msg = (run_status_q == {NOTE_ON, MIDI_CH});

  // State and output registers; reset wins over any byte in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      run_status_q <= 8'h00;
      pending_q    <= 7'h00;
      note_q       <= 7'h00;
      vel_q        <= 7'h00;
      key_on_q     <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      pending_q    <= pending_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
      key_on_q     <= key_on_d;
      strobe_q     <= strobe_d;
    end
  end

  // Parser next-state and note/gate update for the byte in this cycle.
  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    pending_d    = pending_q;
    note_d       = note_q;
    vel_d        = vel_q;
    key_on_d     = key_on_q;
    strobe_d     = 1'b0;

    if (bus.rx_valid) begin
      if (is_status) begin
        if (is_realtime) begin
          // Real-time bytes are transparent to the parser.
        end else if (is_system) begin
          run_status_d = 8'h00;
          state_d      = IDLE;
        end else begin
          // A new status aborts any partial message without touching outputs.
          run_status_d = bus.rx_data;
          state_d      = status_entry(bus.rx_data, MIDI_CH);
        end
      end else begin
        case (state_q)
          IDLE: begin
`ifdef MIDI_RUNNING_STATUS_EN
            // Re-enter as if the retained status had just arrived and
            // consume this byte as the message's first data byte.
            if (run_status_q[7]) begin
              case (status_entry(run_status_q, MIDI_CH))
                NOTE_BYTE: begin
                  pending_d = bus.rx_data[6:0];
                  state_d   = VEL_BYTE;
                end
                SKIP1:   state_d = IDLE;
                default: state_d = SKIP1;
              endcase
            end
`endif
          end
          NOTE_BYTE: begin
            pending_d = bus.rx_data[6:0];
            state_d   = VEL_BYTE;
          end
          VEL_BYTE: begin
            state_d = IDLE;
            if (note_on_msg && bus.rx_data[6:0] != 7'h00) begin
              note_d   = pending_q;
              vel_d    = bus.rx_data[6:0];
              key_on_d = 1'b1;
              strobe_d = 1'b1;
            end else if (key_on_q && pending_q == note_q) begin
              key_on_d = 1'b0;
              strobe_d = 1'b1;
            end
          end
          SKIP2:   state_d = SKIP1;
          SKIP1:   state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign bus.note_out     = {1'b0, note_q};
  assign bus.velocity     = vel_q;
  assign bus.key_on       = key_on_q;
  assign bus.note_strobe  = strobe_q;
  assign bus.parser_state = state_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Self-checking bench for midi_note_decoder: directed scenarios from the
// MIDI message rules plus a randomized byte stream checked against a
// message-level reference model.
module tb_midi_note_decoder;
  import synth_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  midi_note_decoder_if bus ();

  midi_note_decoder #(.MIDI_CH(4'd0)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Message-level model: collect data bytes after a status byte and act
  // once the message is complete.
  logic [7:0] m_status;      // 0 = no running status
  bit         m_open;        // a message is collecting data bytes
  logic [7:0] m_data[$];
  logic [6:0] e_note;
  logic [6:0] e_vel;
  bit         e_key;
  bit         e_strobe;

  function automatic void model_reset();
    m_status = 8'h00;
    m_open   = 1'b0;
    m_data.delete();
    e_note   = 7'h00;
    e_vel    = 7'h00;
    e_key    = 1'b0;
    e_strobe = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int         need;
    logic [6:0] n;
    logic [6:0] v;
    e_strobe = 1'b0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_status = 8'h00;
      m_open   = 1'b0;
      m_data.delete();
      return;
    end
    if (b[7]) begin
      m_status = b;
      m_open   = 1'b1;
      m_data.delete();
      return;
    end
    if (!m_open) begin
`ifdef MIDI_RUNNING_STATUS_EN
      if (m_status != 8'h00) m_open = 1'b1;
`endif
      if (!m_open) return;
    end
    m_data.push_back(b);
    need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
    if (m_data.size() == need) begin
      m_open = 1'b0;
      if (need == 2 && m_status[3:0] == 4'd0 &&
          (m_status[7:4] == 4'h8 || m_status[7:4] == 4'h9)) begin
        n = m_data[0][6:0];
        v = m_data[1][6:0];
        if (m_status[7:4] == 4'h9 && v != 0) begin
          e_note   = n;
          e_vel    = v;
          e_key    = 1'b1;
          e_strobe = 1'b1;
        end else if (e_key && e_note == n) begin
          e_key    = 1'b0;
          e_strobe = 1'b1;
        end
      end
      m_data.delete();
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, output bit stb);
    @(negedge Clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    model_byte(b);
    @(posedge Clk);
    #1;
    bus.rx_valid = 1'b0;
    stb = bus.note_strobe;
  endtask

  task automatic send_seq(input logic [7:0] seq[$], output int nstb, output bit last_stb);
    bit s;
    nstb = 0;
    last_stb = 1'b0;
    foreach (seq[i]) begin
      send_byte(seq[i], s);
      nstb += int'(s);
      last_stb = s;
    end
  endtask

  task automatic apply_reset(input bit with_byte);
    @(negedge Clk);
    Reset = 1'b1;
    if (with_byte) begin
      bus.rx_data  = 8'h90;
      bus.rx_valid = 1'b1;
    end
    @(posedge Clk);
    #1;
    Reset        = 1'b0;
    bus.rx_valid = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset(1'b0);
    checks++;
    if (bus.note_out !== 8'h00) begin errors++; $display("FAIL reset_note: got %h want 00", bus.note_out); end
    checks++;
    if (bus.velocity !== 7'h00) begin errors++; $display("FAIL reset_vel: got %h want 00", bus.velocity); end
    checks++;
    if (bus.key_on !== 1'b0) begin errors++; $display("FAIL reset_key: got %b want 0", bus.key_on); end
    checks++;
    if (bus.note_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", bus.note_strobe); end
    // A status byte coincident with reset must not be parsed.
    apply_reset(1'b1);
    checks++;
    if (bus.parser_state !== IDLE) begin errors++; $display("FAIL reset_priority_state: got %0d want IDLE", bus.parser_state); end
  endtask

  task automatic test_note_on();
    int n; bit last;
    apply_reset(1'b0);
    send_seq('{8'h90, 8'h3C, 8'h64}, n, last);
    checks++;
    if (bus.note_out !== 8'h3C) begin errors++; $display("FAIL on_note: got %h want 3c", bus.note_out); end
    checks++;
    if (bus.velocity !== 7'h64) begin errors++; $display("FAIL on_vel: got %h want 64", bus.velocity); end
    checks++;
    if (bus.key_on !== 1'b1) begin errors++; $display("FAIL on_key: got %b want 1", bus.key_on); end
    checks++;
    if (n !== 1 || last !== 1'b1) begin errors++; $display("FAIL on_strobe: count %0d last %b want 1 1", n, last); end
    @(posedge Clk); #1;
    checks++;
    if (bus.note_strobe !== 1'b0) begin errors++; $display("FAIL on_strobe_width: got %b want 0", bus.note_strobe); end
  endtask

  task automatic test_note_off();
    int n; bit last;
    send_seq('{8'h80, 8'h3C, 8'h00}, n, last);
    checks++;
    if (bus.key_on !== 1'b0 || bus.note_out !== 8'h3C || bus.velocity !== 7'h64) begin
      errors++; $display("FAIL off_outputs: key %b note %h vel %h want 0 3c 64", bus.key_on, bus.note_out, bus.velocity);
    end
    checks++;
    if (n !== 1 || last !== 1'b1) begin errors++; $display("FAIL off_strobe: count %0d want 1", n); end
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h00}, n, last);
    checks++;
    if (bus.key_on !== 1'b0 || bus.note_out !== 8'h3C) begin
      errors++; $display("FAIL on_vel0_outputs: key %b note %h want 0 3c", bus.key_on, bus.note_out);
    end
    checks++;
    if (n !== 2 || last !== 1'b1) begin errors++; $display("FAIL on_vel0_strobe: count %0d want 2", n); end
  endtask

  task automatic test_mismatch();
    int n; bit last;
    send_seq('{8'h90, 8'h3C, 8'h64}, n, last);
    send_seq('{8'h80, 8'h40, 8'h00}, n, last);
    checks++;
    if (bus.key_on !== 1'b1 || bus.note_out !== 8'h3C) begin
      errors++; $display("FAIL mismatch_outputs: key %b note %h want 1 3c", bus.key_on, bus.note_out);
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL mismatch_strobe: count %0d want 0", n); end
  endtask

  task automatic test_retrigger();
    int n; bit last;
    send_seq('{8'h90, 8'h3C, 8'h20}, n, last);
    checks++;
    if (bus.key_on !== 1'b1 || bus.velocity !== 7'h20 || n !== 1) begin
      errors++; $display("FAIL retrigger: key %b vel %h strobes %0d want 1 20 1", bus.key_on, bus.velocity, n);
    end
  endtask

  task automatic test_realtime();
    int n; bit last;
    apply_reset(1'b0);
    send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64}, n, last);
    checks++;
    if (bus.note_out !== 8'h3C || bus.velocity !== 7'h64 || bus.key_on !== 1'b1) begin
      errors++; $display("FAIL realtime_outputs: note %h vel %h key %b want 3c 64 1", bus.note_out, bus.velocity, bus.key_on);
    end
    checks++;
    if (n !== 1 || last !== 1'b1) begin errors++; $display("FAIL realtime_strobe: count %0d want 1", n); end
  endtask

  task automatic test_other_channel();
    int n; bit last;
    send_seq('{8'h91, 8'h3C, 8'h10, 8'hC0, 8'h05, 8'h91, 8'h3C, 8'h00}, n, last);
    checks++;
    if (bus.note_out !== 8'h3C || bus.velocity !== 7'h64 || bus.key_on !== 1'b1 || n !== 0) begin
      errors++; $display("FAIL other_channel: note %h vel %h key %b strobes %0d want 3c 64 1 0",
                         bus.note_out, bus.velocity, bus.key_on, n);
    end
    // System common clears running status; following data bytes do nothing.
    send_seq('{8'hF0, 8'h40, 8'h50, 8'h3C, 8'h00}, n, last);
    checks++;
    if (bus.key_on !== 1'b1 || bus.note_out !== 8'h3C || n !== 0) begin
      errors++; $display("FAIL sysex_ignore: key %b note %h strobes %0d want 1 3c 0", bus.key_on, bus.note_out, n);
    end
  endtask

  task automatic test_running_status();
    int n; bit last;
    logic [7:0] want_note;
    logic [6:0] want_vel;
    int want_n;
`ifdef MIDI_RUNNING_STATUS_EN
    want_note = 8'h40; want_vel = 7'h50; want_n = 2;
`else
    want_note = 8'h3C; want_vel = 7'h64; want_n = 1;
`endif
    apply_reset(1'b0);
    send_seq('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50}, n, last);
    checks++;
    if (bus.note_out !== want_note || bus.velocity !== want_vel || n !== want_n) begin
      errors++; $display("FAIL running_status: note %h vel %h strobes %0d want %h %h %0d",
                         bus.note_out, bus.velocity, n, want_note, want_vel, want_n);
    end
  endtask

  task automatic test_reset_mid_message();
    int n; bit last;
    apply_reset(1'b0);
    send_seq('{8'h90, 8'h3C}, n, last);
    apply_reset(1'b0);
    send_seq('{8'h64}, n, last);
    checks++;
    if (bus.note_out !== 8'h00 || bus.velocity !== 7'h00 || bus.key_on !== 1'b0 || n !== 0) begin
      errors++; $display("FAIL reset_mid_msg: note %h vel %h key %b strobes %0d want 00 00 0 0",
                         bus.note_out, bus.velocity, bus.key_on, n);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] notes[3];
    bit s;
    int r;
    notes[0] = 8'h3C; notes[1] = 8'h3E; notes[2] = 8'h40;
    apply_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 12) b = 8'h90;
      else if (r < 18) b = 8'h80;
      else if (r < 21) b = 8'h91;
      else if (r < 24) b = 8'hC0 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 15));
      else if (r < 27) b = 8'hB0;
      else if (r < 30) b = 8'hF8 | 8'($urandom_range(0, 7));
      else if (r < 32) b = 8'hF0 | 8'($urandom_range(0, 7));
      else if (r < 45) b = 8'h00;
      else if (r < 75) b = notes[$urandom_range(0, 2)];
      else             b = 8'($urandom_range(0, 127));
      send_byte(b, s);
      checks++;
      if (bus.note_out !== {1'b0, e_note} || bus.velocity !== e_vel ||
          bus.key_on !== e_key || s !== e_strobe) begin
        errors++;
        $display("FAIL random[%0d] byte %h: note %h vel %h key %b stb %b want %h %h %b %b",
                 i, b, bus.note_out, bus.velocity, bus.key_on, s, {1'b0, e_note}, e_vel, e_key, e_strobe);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge Clk); #1;
          checks++;
          if (bus.note_strobe !== 1'b0 || bus.key_on !== e_key) begin
            errors++; $display("FAIL random_idle: stb %b key %b want 0 %b", bus.note_strobe, bus.key_on, e_key);
          end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks       = 0;
    errors       = 0;
    Reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    test_reset();
    test_note_on();
    test_note_off();
    test_mismatch();
    test_retrigger();
    test_realtime();
    test_other_channel();
    test_running_status();
    test_reset_mid_message();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
MIDI_NOTE_DECODER -- requirements
Module: midi_note_decoder

Interface
REQ-001 Parameter MIDI_CH, default 4'd0: MIDI channel this decoder responds to.
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  received MIDI byte.
REQ-005 rx_valid  input  1  single-cycle strobe; rx_data is valid while high.
REQ-006 note_out  output  8  current note number, bit 7 always 0; drives a voice's F_in.
REQ-007 velocity  output  7  velocity of the current note.
REQ-008 key_on  output  1  gate; high while the current note is held.
REQ-009 note_strobe  output  1  one-cycle pulse on every key_on rise, retrigger or fall.

Function
REQ-010 Parser states: IDLE, NOTE_BYTE, VEL_BYTE, SKIP1, SKIP2; advance only on rx_valid.
REQ-011 Status byte (bit7=1, < 0xF0): latch it as running status.
- 0x9n/0x8n with n==MIDI_CH -> NOTE_BYTE.
- 0xCn/0xDn (any n) -> SKIP1.
- Other channel messages, or 0x8n/0x9n on another channel -> SKIP2.
REQ-012 0xF8-0xFF (real-time): ignored completely; state, running status and outputs unchanged.
REQ-013 0xF0-0xF7: clear running status -> IDLE; data bytes are then ignored until the next status byte.
REQ-014 A status byte received in any state aborts the message in progress without updating outputs.
REQ-015 NOTE_BYTE + data byte: latch the note into a pending register -> VEL_BYTE.
REQ-016 SKIP2 + data byte -> SKIP1; SKIP1 + data byte -> IDLE.
REQ-017 VEL_BYTE + data byte, for a Note-On with velocity > 0:
- note_out = pending note, velocity = data, key_on = 1, note_strobe = 1.
- This applies even if the same note is already held (retrigger).
REQ-018 VEL_BYTE + data byte, for a Note-Off or a Note-On with velocity 0:
- If pending == note_out and key_on = 1: key_on = 0, note_strobe = 1.
- note_out and velocity are held.
- Otherwise there is no output change.
REQ-019 Outputs update on the edge after the clock sampling the velocity byte (latency 1); note_strobe is high for exactly that one cycle.
REQ-020 After VEL_BYTE the parser returns to IDLE.
REQ-021 Data byte in IDLE is handled per the configuration section.
REQ-022 Monophonic, last-note priority; released notes are not remembered.

Reset
REQ-023 Reset high: on the next edge, state = IDLE; running status, pending note, note_out, velocity, key_on and note_strobe are all cleared to 0.
REQ-024 Reset takes priority over rx_valid in the same cycle.
REQ-025 Reset mid-message discards the partial message; the first byte after reset is parsed from IDLE.

Configuration
REQ-026 Macro MIDI_RUNNING_STATUS_EN, when defined:
- A data byte in IDLE with a valid retained running status re-enters the parser as if that status had just been received.
- The data byte is consumed as the first data byte: note byte -> VEL_BYTE, 1-byte message -> IDLE, 2-byte message -> SKIP1.
REQ-027 Macro MIDI_RUNNING_STATUS_EN undefined: a data byte in IDLE is ignored and running status is never used.

Structure
REQ-028 Package synth_pkg holds:
- the parser state enum;
- MIDI status constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG=4'hC, CHAN_PRESS=4'hD, SYS=4'hF, RT_MIN=8'hF8).
REQ-029 Single module with no sub-modules; the byte source is any UART receiver supplying the rx_data/rx_valid strobe.

Verification
REQ-030 Bytes 90 3C 64:
- note_out=3C, velocity=64, key_on=1.
- One note_strobe, one cycle after the 64 byte.
REQ-031 After REQ-030, bytes 80 3C 00 -> key_on=0 with one strobe, note_out stays 3C. Bytes 90 3C 00 give the same result.
REQ-032 Bytes 90 3C 64 then 80 40 00 -> key_on stays 1, no strobe (note mismatch).
REQ-033 Bytes 90 3C F8 64, real-time byte mid-message -> same result as REQ-030.
REQ-034 Bytes 91 3C 64 (wrong channel) and C0 05 -> no output change, no strobe.
REQ-035 With MIDI_RUNNING_STATUS_EN: bytes 90 3C 64 40 50 -> note_out=40, velocity=50, two strobes. Without the macro -> note_out=3C, one strobe. In both builds, Reset asserted after 90 3C, then 64 -> no change, all outputs 0.
